// File: rtl/board_pkg.sv
// board_pkg -- definitions shared by the board transmitter (send_board) and
// the matching receiver.
//   BOARD_BITS_DFLT : default number of board cells in one frame
//   board_state_e   : frame sequencing states (IDLE, SEND, DONE)
package board_pkg;

  localparam int BOARD_BITS_DFLT = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } board_state_e;

endpackage

// File: rtl/send_board_if.sv
// send_board_if -- groups the signals between a board source and the
// serialiser.
//   board    : board image, cell i = bit i (source -> serialiser)
//   start    : request to send a frame        (source -> serialiser)
//   data_out : serial bit stream              (serialiser -> downstream)
//   sof      : marks the cycle carrying cell 0
//   busy     : frame being shifted
//   done     : one-cycle pulse after the last frame bit
// modport master : the side that supplies the board and the start request
// modport slave  : the serialiser itself
interface send_board_if #(
  parameter int BOARD_BITS = board_pkg::BOARD_BITS_DFLT
);

  logic [BOARD_BITS-1:0] board;
  logic                  start;
  logic                  data_out;
  logic                  sof;
  logic                  busy;
  logic                  done;

  modport master (
    output board, start,
    input  data_out, sof, busy, done
  );

  modport slave (
    input  board, start,
    output data_out, sof, busy, done
  );

endinterface

// File: rtl/send_board.sv
// send_board -- serialises a BOARD_BITS-wide board image, LSB first, one bit
// per clk.
// Ports:
//   clk   : single clock, all state changes on posedge
//   reset : asynchronous, active-low
//   bus   : send_board_if.slave (board, start in; data_out, sof, busy, done out)
// Build option:
//   SEND_BOARD_PARITY_EN : when defined, one even-parity bit (XOR of the
//   snapshot) follows cell BOARD_BITS-1, making the frame BOARD_BITS+1 long.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; outputs low
// SEND  | shifting the snapshot (and the parity bit when enabled), busy=1
// DONE  | single cycle with done=1, then back to IDLE
//
// All outputs come straight from flops; their next values are computed
// alongside the next state so the first data bit appears in the first SEND
// cycle. BOARD_BITS must be at least 2.
module send_board
  import board_pkg::*;
#(
  parameter int BOARD_BITS = BOARD_BITS_DFLT
) (
  input  logic         clk,
  input  logic         reset,
  send_board_if.slave  bus
);

  localparam int CNT_W = (BOARD_BITS > 1) ? $clog2(BOARD_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BOARD_BITS - 1);

  board_state_e          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BOARD_BITS-1:0] shreg_q, shreg_d;
  logic                  data_out_q, data_out_d;
  logic                  sof_q, sof_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef SEND_BOARD_PARITY_EN
  logic                  par_q, par_d;
  logic                  par_phase_q, par_phase_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      data_out_q  <= 1'b0;
      sof_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SEND_BOARD_PARITY_EN
      par_q       <= 1'b0;
      par_phase_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      data_out_q  <= data_out_d;
      sof_q       <= sof_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SEND_BOARD_PARITY_EN
      par_q       <= par_d;
      par_phase_q <= par_phase_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    data_out_d  = 1'b0;
    sof_d       = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
`ifdef SEND_BOARD_PARITY_EN
    par_d       = par_q;
    par_phase_d = par_phase_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = SEND;
          cnt_d      = '0;
          shreg_d    = bus.board;
          data_out_d = bus.board[0];
          sof_d      = 1'b1;
          busy_d     = 1'b1;
`ifdef SEND_BOARD_PARITY_EN
          par_d       = ^bus.board;
          par_phase_d = 1'b0;
`endif
        end
      end

      SEND: begin
        if (cnt_q != CNT_LAST) begin
          // Rotate rather than shift so the cell on the wire is always bit 0
          // and every register bit stays in use.
          cnt_d      = cnt_q + 1'b1;
          shreg_d    = {shreg_q[0], shreg_q[BOARD_BITS-1:1]};
          data_out_d = shreg_q[1];
          busy_d     = 1'b1;
        end else begin
          // Counter parks at its last value; it never wraps back into SEND.
`ifdef SEND_BOARD_PARITY_EN
          if (!par_phase_q) begin
            par_phase_d = 1'b1;
            data_out_d  = par_q;
            busy_d      = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
`else
          state_d = DONE;
          done_d  = 1'b1;
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.data_out = data_out_q;
  assign bus.sof      = sof_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: doc/send_board.md
SEND_BOARD -- requirements
Module: send_board

Interface
REQ-001 SHALL have parameter: BOARD_BITS, 256, number of board cells serialised per frame.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL have port: board  input  BOARD_BITS  board image to transmit; cell i = bit i.
REQ-005 SHALL have port: start  input  1  request to send; sampled only in IDLE.
REQ-006 SHALL have port: data_out  output  1  serial bit stream to the downstream receiver.
REQ-007 SHALL have port: sof  output  1  high during the cycle data_out carries cell 0.
REQ-008 SHALL have port: busy  output  1  high while a frame is being shifted.
REQ-009 SHALL have port: done  output  1  one-cycle pulse after the last frame bit.

Function
REQ-010 SHALL implement FSM states IDLE, SEND, DONE.
REQ-011 SHALL, in IDLE on posedge with start=1, snapshot board into a shift register, clear bit counter and enter SEND.
REQ-012 SHALL, in SEND, drive data_out = cell k during the k-th SEND cycle (k = 0..BOARD_BITS-1), LSB first, one bit per clock.
REQ-013 SHALL assert sof only in SEND cycle k=0.
REQ-014 SHALL hold busy=1 for every SEND cycle and 0 in IDLE and DONE.
REQ-015 SHALL use a bit counter of clog2(BOARD_BITS) bits; counter value BOARD_BITS-1 is the last data bit and the counter SHALL NOT wrap back into SEND.
REQ-016 SHALL go SEND -> DONE after the last frame bit; DONE -> IDLE unconditionally after one cycle.
REQ-017 SHALL assert done=1 only in the DONE cycle.
REQ-018 SHALL ignore start in SEND and DONE (no queuing); a start held high through DONE launches the next frame from IDLE one cycle later.
REQ-019 SHALL ignore changes on board after the snapshot; transmitted frame equals board at the accepting edge.
REQ-020 SHALL drive data_out=0 and sof=0 in IDLE and DONE.
REQ-021 SHALL make all outputs registered (no combinational path from start/board to outputs).

Reset
REQ-022 SHALL, with reset=0, immediately force state IDLE, counter 0, shift register 0, data_out=0, sof=0, busy=0, done=0.
REQ-023 SHALL abort a frame in progress on reset assertion without emitting done.
REQ-024 SHALL accept start on the first posedge after reset deassertion.

Configuration
REQ-025 SHALL, when macro SEND_BOARD_PARITY_EN is defined, append one even-parity bit (XOR of all BOARD_BITS snapshot bits) as an extra SEND cycle after cell BOARD_BITS-1, busy=1, frame length BOARD_BITS+1 cycles.
REQ-026 SHALL, when SEND_BOARD_PARITY_EN is undefined, send exactly BOARD_BITS bits with no parity logic present.

Structure
REQ-027 SHALL take BOARD_BITS default and the FSM state enumeration (IDLE, SEND, DONE) from shared package board_pkg, also used by the receiver.
REQ-028 SHALL keep the shift register, FSM and counter in one module; no sub-module is required.

Verification
REQ-029 SHALL verify: reset low then high, start=1 one cycle, board=256'h...AAAA (alternating) -> data_out 0,1,0,1... for 256 cycles, sof on first, done pulse on cycle 257, busy low after.
REQ-030 SHALL verify: board=256'h1 -> sof and data_out=1 in same cycle, data_out=0 for remaining 255 SEND cycles.
REQ-031 SHALL verify: board changed to all-ones on cycle 10 of a frame of zeros -> all 256 transmitted bits remain 0.
REQ-032 SHALL verify: reset asserted at SEND cycle 100 -> busy, data_out, sof drop same cycle, no done pulse; new start afterwards sends full frame from cell 0.
REQ-033 SHALL verify: start held high continuously -> back-to-back frames separated by DONE and IDLE cycles (258-cycle period without parity).
REQ-034 SHALL verify with SEND_BOARD_PARITY_EN defined: board with three 1s -> bit 256 = 1, done on cycle 258; board all zeros -> parity bit 0.
